// File: rtl/multi_wave_gen.sv
// multi_wave_gen: NUM_CH phase-accumulator channels (saw / triangle / pulse / off) with
// shadowed valid/ready config writes and an atomic commit. Optional macro: MULTI_WAVE_GEN_GAIN_EN.
// Latency 2 cycles accumulator->wave_out (3 with gain); cfg_ready drops for one cycle after commit.
module multi_wave_gen #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sync,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_chan,
  input  logic [2:0]              cfg_field,
  input  logic [ACC_W-1:0]        cfg_data,
  input  logic                    commit,
  output logic [NUM_CH*OUT_W-1:0] wave_out,
  output logic                    out_valid,
  output logic [NUM_CH-1:0]       wrap
);

  localparam logic [OUT_W-1:0] POS_FS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_FS = {1'b1, {(OUT_W-1){1'b0}}};

  localparam logic [2:0] F_FREQ  = 3'd0;
  localparam logic [2:0] F_PHASE = 3'd1;
  localparam logic [2:0] F_MODE  = 3'd2;
  localparam logic [2:0] F_DUTY  = 3'd3;
`ifdef MULTI_WAVE_GEN_GAIN_EN
  localparam logic [2:0] F_GAIN  = 3'd4;
  localparam logic [OUT_W-1:0] UNITY = OUT_W'(1) << (OUT_W-1);
`endif

  // Shadow (host-written) and active (in-use) configuration
  logic [NUM_CH-1:0][ACC_W-1:0] sh_freq, sh_phase, sh_duty;
  logic [NUM_CH-1:0][ACC_W-1:0] ac_freq, ac_phase, ac_duty;
  logic [NUM_CH-1:0][1:0]       sh_mode, ac_mode;
`ifdef MULTI_WAVE_GEN_GAIN_EN
  logic [NUM_CH-1:0][OUT_W-1:0] sh_gain, ac_gain;
`endif

  logic                         wr_en;
  logic [NUM_CH-1:0][ACC_W-1:0] acc;
  logic [NUM_CH-1:0][ACC_W-1:0] p;
  logic                         en_d1;
  logic [NUM_CH-1:0][OUT_W-1:0] shaped;
  logic [NUM_CH-1:0][OUT_W-1:0] s2;
  logic                         en_d2;

  assign wr_en = cfg_valid & cfg_ready;

  // Waveform shaping of one phase value
  function automatic logic [OUT_W-1:0] shape(input logic [ACC_W-1:0] ph,
                                             input logic [1:0]       md,
                                             input logic [ACC_W-1:0] dt);
    logic [OUT_W-1:0] t, u, v;
    t = ph[ACC_W-1 -: OUT_W];
    u = ph[ACC_W-2 -: OUT_W];
    v = ph[ACC_W-1] ? ~u : u;
    case (md)
      2'b00:   shape = {~t[OUT_W-1], t[OUT_W-2:0]};
      2'b01:   shape = {~v[OUT_W-1], v[OUT_W-2:0]};
      2'b10:   shape = (ph < dt) ? POS_FS : NEG_FS;
      default: shape = '0;
    endcase
  endfunction

  // Shadow writes, shadow->active copy on commit, ready gap right after a commit.
  // The copy uses the pre-edge shadow, so a write on the commit edge waits for the next commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
      sh_freq   <= '0;
      sh_phase  <= '0;
      sh_duty   <= '0;
      sh_mode   <= {NUM_CH{2'b11}};
      ac_freq   <= '0;
      ac_phase  <= '0;
      ac_duty   <= '0;
      ac_mode   <= {NUM_CH{2'b11}};
`ifdef MULTI_WAVE_GEN_GAIN_EN
      sh_gain   <= {NUM_CH{UNITY}};
      ac_gain   <= {NUM_CH{UNITY}};
`endif
    end else begin
      cfg_ready <= ~commit;
      if (commit) begin
        ac_freq  <= sh_freq;
        ac_phase <= sh_phase;
        ac_duty  <= sh_duty;
        ac_mode  <= sh_mode;
`ifdef MULTI_WAVE_GEN_GAIN_EN
        ac_gain  <= sh_gain;
`endif
      end
      if (wr_en) begin
        // Out-of-range channels match no index and are silently dropped
        for (int i = 0; i < NUM_CH; i++) begin
          if (cfg_chan == CH_W'(i)) begin
            case (cfg_field)
              F_FREQ:  sh_freq[i]  <= cfg_data;
              F_PHASE: sh_phase[i] <= cfg_data;
              F_MODE:  sh_mode[i]  <= cfg_data[1:0];
              F_DUTY:  sh_duty[i]  <= cfg_data;
`ifdef MULTI_WAVE_GEN_GAIN_EN
              F_GAIN:  sh_gain[i]  <= cfg_data[OUT_W-1:0];
`endif
              default: ;
            endcase
          end
        end
      end
    end
  end

  // Phase accumulators: sync clears without a wrap, otherwise advance while enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      wrap <= '0;
    end else if (sync) begin
      acc  <= '0;
      wrap <= '0;
    end else if (enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        {wrap[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, ac_freq[i]};
      end
    end else begin
      wrap <= '0;
    end
  end

  // Stage 1: apply phase offset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p     <= '0;
      en_d1 <= 1'b0;
    end else begin
      en_d1 <= enable;
      for (int i = 0; i < NUM_CH; i++) begin
        p[i] <= acc[i] + ac_phase[i];
      end
    end
  end

  // Stage 2 combinational shaping per channel
  always_comb begin
    shaped = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      shaped[i] = shape(p[i], ac_mode[i], ac_duty[i]);
    end
  end

  // Stage 2 register: only samples from enabled cycles replace the held output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2    <= '0;
      en_d2 <= 1'b0;
    end else begin
      en_d2 <= en_d1;
      if (en_d1) s2 <= shaped;
    end
  end

`ifdef MULTI_WAVE_GEN_GAIN_EN
  logic [NUM_CH-1:0][OUT_W-1:0] s3;
  logic                         en_d3;

  // Signed sample times unsigned Q1.(OUT_W-1) gain, saturated back to OUT_W bits
  function automatic logic [OUT_W-1:0] apply_gain(input logic [OUT_W-1:0] s,
                                                  input logic [OUT_W-1:0] g);
    logic signed [2*OUT_W:0] sx, gx, prod, scl;
    sx   = {{(OUT_W+1){s[OUT_W-1]}}, s};
    gx   = {{(OUT_W+1){1'b0}}, g};
    prod = sx * gx;
    scl  = prod >>> (OUT_W-1);
    if (scl[2*OUT_W:OUT_W-1] == '0 || scl[2*OUT_W:OUT_W-1] == '1)
      apply_gain = scl[OUT_W-1:0];
    else
      apply_gain = scl[2*OUT_W] ? NEG_FS : POS_FS;
  endfunction

  // Stage 3: gain and saturation, holding the output between valid samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3    <= '0;
      en_d3 <= 1'b0;
    end else begin
      en_d3 <= en_d2;
      if (en_d2) begin
        for (int i = 0; i < NUM_CH; i++) begin
          s3[i] <= apply_gain(s2[i], ac_gain[i]);
        end
      end
    end
  end

  assign wave_out  = s3;
  assign out_valid = en_d3;
`else
  assign wave_out  = s2;
  assign out_valid = en_d2;
`endif

endmodule

// File: tb/tb_multi_wave_gen.sv
// Self-checking bench for multi_wave_gen (3-channel instance so channel index 3 is out of range).
// Expected samples are queued as stimulus is issued and popped when out_valid presents a sample.
`timescale 1ns/1ps
module tb_multi_wave_gen;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int OUT_W  = 16;
  localparam int ACC_W  = 32;
`ifdef MULTI_WAVE_GEN_GAIN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        commit = 1'b0;
  logic [1:0]  cfg_chan = '0;
  logic [2:0]  cfg_field = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready;
  logic [47:0] wave_out;
  logic        out_valid;
  logic [2:0]  wrap;

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] exp_q[$];

  logic [15:0] saw4 [4] = '{16'h8000, 16'hC000, 16'h0000, 16'h4000};
  logic [15:0] tri4 [4] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};

  always #5 clk = ~clk;

  multi_wave_gen #(.NUM_CH(NUM_CH), .CH_W(CH_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .commit(commit),
    .wave_out(wave_out), .out_valid(out_valid), .wrap(wrap)
  );

  function automatic logic [47:0] pk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {c, b, a};
  endfunction

  task automatic cfg_write(input logic [1:0] ch, input logic [2:0] fld, input logic [31:0] dat);
    int t;
    @(negedge clk);
    t = 0;
    while (cfg_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cfg_write_ready: cfg_ready=%b required 1", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_chan = ch; cfg_field = fld; cfg_data = dat;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    sync = 1'b1; enable = 1'b0;
    @(negedge clk);
    sync = 1'b0; enable = 1'b1;
  endtask

  task automatic stop_run();
    enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wave_out !== 48'h0 || out_valid !== 1'b0 || cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: wave_out=%h out_valid=%b cfg_ready=%b required 0/0/0", wave_out, out_valid, cfg_ready);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_ready: cfg_ready=%b required 0", cfg_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_ready !== 1'b1 || out_valid !== 1'b0 || wave_out !== 48'h0) begin
      n_err++;
      $display("FAIL reset_first_edge: cfg_ready=%b out_valid=%b wave_out=%h required 1/0/0", cfg_ready, out_valid, wave_out);
    end
  endtask

  task automatic test_saw();
    int got, first_c;
    logic [47:0] e;
    logic [2:0]  ew;
    cfg_write(2'd0, 3'd0, 32'h4000_0000);
    cfg_write(2'd0, 3'd2, 32'h0);
    do_commit();
    start_run();
    for (int k = 0; k < 8; k++) exp_q.push_back(pk(saw4[k % 4], 16'h0, 16'h0));
    got = 0; first_c = -1;
    for (int c = 1; c <= 40 && got < 8; c++) begin
      @(negedge clk);
      ew = (c % 4 == 0) ? 3'b001 : 3'b000;
      n_cmp++;
      if (wrap !== ew) begin
        n_err++;
        $display("FAIL saw_wrap_c%0d: wrap=%b required %b", c, wrap, ew);
      end
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL saw_queue: sample %h with empty queue", wave_out);
        end else begin
          e = exp_q.pop_front();
          if (wave_out !== e) begin
            n_err++;
            $display("FAIL saw_sample%0d: wave_out=%h required %h", got, wave_out, e);
          end
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 8) begin
      n_err++;
      $display("FAIL saw_timeout: samples=%0d required 8", got);
    end
    n_cmp++;
    if (first_c != LAT) begin
      n_err++;
      $display("FAIL saw_latency: cycles=%0d required %0d", first_c, LAT);
    end
    stop_run();
    n_cmp++;
    if (out_valid !== 1'b0 || wave_out !== pk(16'h8000, 16'h0, 16'h0) || wrap !== 3'b000) begin
      n_err++;
      $display("FAIL saw_hold: out_valid=%b wave_out=%h wrap=%b required 0/%h/000", out_valid, wave_out, wrap, pk(16'h8000, 16'h0, 16'h0));
    end
  endtask

  task automatic test_pulse();
    int got;
    logic [47:0] e;
    cfg_write(2'd1, 3'd0, 32'h2000_0000);
    cfg_write(2'd1, 3'd3, 32'h8000_0000);
    cfg_write(2'd1, 3'd2, 32'h2);
    do_commit();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        cfg_write(2'd1, 3'd3, 32'h0);
        do_commit();
      end
      start_run();
      for (int k = 0; k < 8; k++)
        exp_q.push_back(pk(saw4[k % 4], (pass == 0 && k < 4) ? 16'h7FFF : 16'h8000, 16'h0));
      got = 0;
      for (int c = 1; c <= 40 && got < 8; c++) begin
        @(negedge clk);
        if (out_valid) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pulse_queue: sample %h with empty queue", wave_out);
          end else begin
            e = exp_q.pop_front();
            if (wave_out !== e) begin
              n_err++;
              $display("FAIL pulse_p%0d_sample%0d: wave_out=%h required %h", pass, got, wave_out, e);
            end
          end
          got++;
        end
      end
      n_cmp++;
      if (got != 8) begin
        n_err++;
        $display("FAIL pulse_timeout: samples=%0d required 8", got);
      end
      stop_run();
    end
  endtask

  task automatic test_atomic();
    int got;
    logic [47:0] e;
    cfg_write(2'd2, 3'd2, 32'h0);
    do_commit();
    cfg_write(2'd0, 3'd0, 32'h1000_0000);
    cfg_write(2'd2, 3'd0, 32'h4000_0000);
    for (int step = 0; step < 3; step++) begin
      if (step == 1) begin
        @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
          n_err++;
          $display("FAIL atomic_ready_pre: cfg_ready=%b required 1", cfg_ready);
        end
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_field = 3'd2; cfg_data = 32'h3; commit = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; commit = 1'b0;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
          n_err++;
          $display("FAIL atomic_ready_gap: cfg_ready=%b required 0", cfg_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
          n_err++;
          $display("FAIL atomic_ready_back: cfg_ready=%b required 1", cfg_ready);
        end
      end
      if (step == 2) do_commit();
      start_run();
      for (int k = 0; k < 4; k++) begin
        if (step == 0)      exp_q.push_back(pk(saw4[k], 16'h8000, 16'h8000));
        else if (step == 1) exp_q.push_back(pk(16'(16'h8000 + k * 16'h1000), 16'h8000, saw4[k]));
        else                exp_q.push_back(pk(16'h0, 16'h8000, saw4[k]));
      end
      got = 0;
      for (int c = 1; c <= 40 && got < 4; c++) begin
        @(negedge clk);
        if (out_valid) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL atomic_queue: sample %h with empty queue", wave_out);
          end else begin
            e = exp_q.pop_front();
            if (wave_out !== e) begin
              n_err++;
              $display("FAIL atomic_s%0d_sample%0d: wave_out=%h required %h", step, got, wave_out, e);
            end
          end
          got++;
        end
      end
      n_cmp++;
      if (got != 4) begin
        n_err++;
        $display("FAIL atomic_timeout: samples=%0d required 4", got);
      end
      stop_run();
    end
  endtask

  task automatic test_phase();
    int got;
    logic [47:0] e;
    logic [15:0] a;
    cfg_write(2'd0, 3'd2, 32'h0);
    cfg_write(2'd1, 3'd0, 32'h1000_0000);
    cfg_write(2'd1, 3'd1, 32'h8000_0000);
    cfg_write(2'd1, 3'd2, 32'h0);
    cfg_write(2'd2, 3'd2, 32'h1);
    cfg_write(2'd3, 3'd0, 32'hFFFF_FFFF);
    cfg_write(2'd3, 3'd2, 32'h1);
    cfg_write(2'd0, 3'd5, 32'hDEAD_BEEF);
    cfg_write(2'd2, 3'd7, 32'h1234_5678);
`ifndef MULTI_WAVE_GEN_GAIN_EN
    cfg_write(2'd0, 3'd4, 32'h0000_0001);
`endif
    do_commit();
    start_run();
    for (int k = 0; k < 8; k++) begin
      a = 16'(k * 16'h1000) ^ 16'h8000;
      exp_q.push_back(pk(a, a ^ 16'h8000, tri4[k % 4]));
    end
    got = 0;
    for (int c = 1; c <= 40 && got < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL phase_queue: sample %h with empty queue", wave_out);
        end else begin
          e = exp_q.pop_front();
          if (wave_out !== e) begin
            n_err++;
            $display("FAIL phase_sample%0d: wave_out=%h required %h", got, wave_out, e);
          end
        end
        n_cmp++;
        if ((wave_out[31:16] ^ wave_out[15:0]) !== 16'h8000) begin
          n_err++;
          $display("FAIL phase_align%0d: ch0^ch1=%h required 8000", got, wave_out[31:16] ^ wave_out[15:0]);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 8) begin
      n_err++;
      $display("FAIL phase_timeout: samples=%0d required 8", got);
    end
    stop_run();
  endtask

  task automatic test_async_reset();
    cfg_write(2'd2, 3'd2, 32'h0);
    start_run();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL areset_running: out_valid=%b required 1", out_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (wave_out !== 48'h0 || out_valid !== 1'b0 || wrap !== 3'b000 || cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL areset_immediate: wave_out=%h out_valid=%b wrap=%b cfg_ready=%b required 0/0/0/0", wave_out, out_valid, wrap, cfg_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    do_commit();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || wave_out !== 48'h0) begin
      n_err++;
      $display("FAIL areset_modes_off: out_valid=%b wave_out=%h required 1/0", out_valid, wave_out);
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_saw();
    test_pulse();
    test_atomic();
    test_phase();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
